// File: rtl/segment_pkg.sv
// ---------------------------------------------------------------------------
// segment_pkg
// Shared constants and types for the segment_formatter block:
//   - SEG_DIGIT[0:9] : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   - SEG_BLANK      : all segments off
//   - SEG_DASH       : middle segment only, shown on every digit on overflow
//   - fmt_state_t    : conversion FSM states
//   - BCD_DIGITS, MAX_DISPLAY, VALUE_W, LAST_STEP : sizing constants
// ---------------------------------------------------------------------------
package segment_pkg;

    localparam int unsigned VALUE_W     = 14;
    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned MAX_DISPLAY = 9999;

    // Counter value of the final shift step (14 steps: 0..13).
    localparam logic [3:0] LAST_STEP = 4'(VALUE_W - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } fmt_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// ---------------------------------------------------------------------------
// bcd_to_seg
// Combinational decoder from one BCD nibble to an active-low 7-segment
// pattern. Codes 10..15 are not valid BCD and map to SEG_BLANK.
// Ports:
//   i_bcd [3:0] : BCD digit
//   o_seg [6:0] : {g,f,e,d,c,b,a}, 0 = segment lit
// ---------------------------------------------------------------------------
module bcd_to_seg
    import segment_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_bcd <= 4'd9) begin
            o_seg = SEG_DIGIT[i_bcd];
        end
    end

endmodule

// File: rtl/segment_formatter.sv
// ---------------------------------------------------------------------------
// segment_formatter
// Converts a 14-bit binary value into four 7-segment digit patterns using a
// sequential double-dabble (shift-add-3) conversion, one step per clock.
// Results are registered and replace the previous patterns all at once.
//
// Ports:
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   value    : binary value, sampled on an accepted load
//   load     : conversion request, accepted only while busy = 0
//   seg0..3  : ones..thousands digit patterns, active-low {g,f,e,d,c,b,a}
//   busy     : conversion in progress
//   done     : one-cycle pulse when new patterns appear
//   overflow : last accepted value exceeded 9999 (all digits show a dash)
//
// Build option:
//   SEGMENT_FORMATTER_LZB_EN : when defined, leading zeros on seg3..seg1 are
//                              blanked; seg0 always shows its digit.
// ---------------------------------------------------------------------------
module segment_formatter
    import segment_pkg::*;
#(
    parameter int unsigned VALUE_W = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic [6:0]         seg0,
    output logic [6:0]         seg1,
    output logic [6:0]         seg2,
    output logic [6:0]         seg3,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam logic [VALUE_W-1:0] W_MAX = VALUE_W'(MAX_DISPLAY);

    fmt_state_t                r_state;
    fmt_state_t                w_state_next;

    logic [VALUE_W-1:0]        r_shift;
    logic [4*BCD_DIGITS-1:0]   r_bcd;
    logic [3:0]                r_cnt;
    logic                      r_ovf_pend;
    logic [6:0]                r_seg [0:BCD_DIGITS-1];
    logic                      r_done;
    logic                      r_overflow;

    logic [4*BCD_DIGITS-1:0]   w_bcd_adj;
    logic [6:0]                w_pat      [0:BCD_DIGITS-1];
    logic [6:0]                w_seg_next [0:BCD_DIGITS-1];

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and busy
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_next = UPDATE;
                end
            end
            UPDATE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Add-3 correction applied to every nibble before the shift
    // -----------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = '0;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end else begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Digit decoders
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dec
        bcd_to_seg u_bcd_to_seg (
            .i_bcd (r_bcd[4*g +: 4]),
            .o_seg (w_pat[g])
        );
    end

    // -----------------------------------------------------------------------
    // Final pattern selection: overflow dash, optional leading-zero blanking
    // -----------------------------------------------------------------------
    always_comb begin
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            w_seg_next[i] = w_pat[i];
        end
        if (r_ovf_pend) begin
            // The accumulator only holds four digits, so its contents are
            // meaningless here; the dash replaces every digit.
            for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
                w_seg_next[i] = SEG_DASH;
            end
        end else begin
`ifdef SEGMENT_FORMATTER_LZB_EN
            if (r_bcd[15:12] == 4'd0) begin
                w_seg_next[3] = SEG_BLANK;
            end
            if (r_bcd[15:8] == 8'd0) begin
                w_seg_next[2] = SEG_BLANK;
            end
            if (r_bcd[15:4] == 12'd0) begin
                w_seg_next[1] = SEG_BLANK;
            end
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
                r_seg[i] <= SEG_BLANK;
            end
        end else begin
            r_done <= (r_state == UPDATE);
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift    <= value;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (value > W_MAX);
                    end
                end
                CONVERT: begin
                    r_bcd   <= {w_bcd_adj[4*BCD_DIGITS-2:0], r_shift[VALUE_W-1]};
                    r_shift <= {r_shift[VALUE_W-2:0], 1'b0};
                    r_cnt   <= r_cnt + 4'd1;
                end
                UPDATE: begin
                    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
                        r_seg[i] <= w_seg_next[i];
                    end
                    r_overflow <= r_ovf_pend;
                end
                default: begin
                end
            endcase
        end
    end

    assign seg0     = r_seg[0];
    assign seg1     = r_seg[1];
    assign seg2     = r_seg[2];
    assign seg3     = r_seg[3];
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_segment_formatter.sv
// ---------------------------------------------------------------------------
// tb_segment_formatter
// Self-checking bench for segment_formatter. Expected patterns come from a
// decimal-arithmetic model of the display (value % 10, / 10, ...), not from
// the shift-add-3 algorithm. Honours SEGMENT_FORMATTER_LZB_EN the same way
// the design does.
// ---------------------------------------------------------------------------
module tb_segment_formatter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [13:0] value = '0;
    logic [6:0]  seg0, seg1, seg2, seg3;
    logic        busy, done, overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [27:0] exp_segs;   // {seg3, seg2, seg1, seg0}
    logic        exp_ovf;

    always #5 clk = ~clk;

    segment_formatter #(.VALUE_W(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .seg0     (seg0),
        .seg1     (seg1),
        .seg2     (seg2),
        .seg3     (seg3),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] digit_pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Reference model: what the display must show for value v.
    task automatic model_set(input int v);
        logic [6:0] p3, p2, p1, p0;
        if (v > 9999) begin
            exp_segs = {4{7'b0111111}};
            exp_ovf  = 1'b1;
        end else begin
            p0 = digit_pat(v % 10);
            p1 = digit_pat((v / 10) % 10);
            p2 = digit_pat((v / 100) % 10);
            p3 = digit_pat(v / 1000);
`ifdef SEGMENT_FORMATTER_LZB_EN
            if (v < 1000) p3 = 7'b1111111;
            if (v < 100)  p2 = 7'b1111111;
            if (v < 10)   p1 = 7'b1111111;
`endif
            exp_segs = {p3, p2, p1, p0};
            exp_ovf  = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One conversion: drive load at a negedge, follow busy/done, check result.
    // inject: extra load pulses during the conversion (must be ignored).
    // chained: return in the done cycle so the caller can load immediately.
    task automatic run_conv(input int v, input bit inject, input bit chained);
        logic [27:0] prev_segs;
        int          busy_cnt;
        bit          got_done;
        prev_segs = exp_segs;
        busy_cnt  = 0;
        got_done  = 1'b0;
        load  = 1'b1;
        value = 14'(v);
        tick();
        load = 1'b0;
        for (int k = 1; k <= 40 && !got_done; k++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                check("busy_phase", 32'({busy, done}), 32'b10);
                busy_cnt++;
                if (k == 8) check("seg_hold", 32'({seg3, seg2, seg1, seg0}), 32'(prev_segs));
                if (inject && (k == 3 || k == 8)) begin
                    load  = 1'b1;
                    value = 14'($urandom);
                end else begin
                    load = 1'b0;
                end
                tick();
            end
        end
        load = 1'b0;
        model_set(v);
        check("done_seen", 32'(got_done), 32'd1);
        check("busy_cycles", 32'(busy_cnt), 32'd15);
        check("busy_in_done", 32'(busy), 32'd0);
        check("segments", 32'({seg3, seg2, seg1, seg0}), 32'(exp_segs));
        check("overflow", 32'(overflow), 32'(exp_ovf));
        if (!chained) begin
            tick();
            check("done_pulse", 32'({busy, done}), 32'b00);
            check("seg_after", 32'({seg3, seg2, seg1, seg0}), 32'(exp_segs));
        end
    endtask

    initial begin
        exp_segs = {4{7'b1111111}};
        exp_ovf  = 1'b0;

        // Reset state
        rst_n = 1'b0;
        tick();
        check("rst_segs", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'b1111111}}));
        check("rst_flags", 32'({busy, done, overflow}), 32'b000);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_done_idle", 32'({busy, done}), 32'b00);
        end

        // Directed values
        run_conv(1234, 1'b0, 1'b0);
        run_conv(7, 1'b0, 1'b0);
        run_conv(9999, 1'b0, 1'b0);
        run_conv(10000, 1'b0, 1'b0);
        run_conv(0, 1'b0, 1'b0);
        run_conv(16383, 1'b0, 1'b0);
        run_conv(5678, 1'b1, 1'b0);   // loads during busy ignored
        run_conv(321, 1'b0, 1'b1);    // next load lands in the done cycle
        run_conv(4005, 1'b0, 1'b0);

        // Reset in the middle of a conversion
        load  = 1'b1;
        value = 14'd1234;
        tick();
        load = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_segs", 32'({seg3, seg2, seg1, seg0}), 32'({4{7'b1111111}}));
        check("midrst_flags", 32'({busy, done, overflow}), 32'b000);
        @(negedge clk);
        rst_n = 1'b1;
        exp_segs = {4{7'b1111111}};
        exp_ovf  = 1'b0;
        tick();
        run_conv(42, 1'b0, 1'b0);

        // Randomized values, biased toward the 9999/10000 boundary
        for (int n = 0; n < 24; n++) begin
            int v;
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(9990, 10010));
                1:       v = int'($urandom_range(0, 120));
                default: v = int'($urandom_range(0, 16383));
            endcase
            run_conv(v, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/segment_formatter.md
# segment_formatter

- Converts a 14-bit binary value into four 7-segment digit patterns using a sequential double-dabble (shift-add-3) conversion.
- Sits directly upstream of the four-digit segment multiplexer; its `seg0`..`seg3` outputs drive that block's digit inputs.
- Outputs are registered and update atomically, so the display never shows a partially converted value.

## Interface
- `VALUE_W`, 14: input value width; fixed at 14 (range 0–16383).
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  14  binary value to display; sampled only on an accepted `load`.
- `load`  in  1  request conversion; accepted when `busy`=0.
- `seg0`  out  7  ones-digit pattern, `{g,f,e,d,c,b,a}`, active-low (0 = segment lit).
- `seg1`  out  7  tens-digit pattern.
- `seg2`  out  7  hundreds-digit pattern.
- `seg3`  out  7  thousands-digit pattern.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse when the new patterns appear on `seg0`..`seg3`.
- `overflow`  out  1  registered; high when the last accepted value exceeded 9999.

## Operation
- FSM states: IDLE, CONVERT, UPDATE; `busy` = (state != IDLE).
- IDLE:
  - `load`=1 captures `value` into a 14-bit shift register.
  - Clears the 16-bit BCD accumulator and the 4-bit step counter; goes to CONVERT.
- CONVERT, one step per cycle:
  - Any BCD nibble ≥5 gets +3.
  - Then {BCD, shift} shifts left by 1.
  - Counter increments; after step 13 (14 steps total), goes to UPDATE.
- UPDATE:
  - Decodes nibbles into `seg0`..`seg3` and updates `overflow`.
  - Pulses `done`; returns to IDLE.
- Overflow: captured value >9999 → all four digits show dash `7'b0111111`, `overflow`=1. Otherwise `overflow`=0.
- Digit patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Blank = 1111111.
- `load` while `busy`=1 is ignored; it is not queued.
- Segment outputs hold their previous values through CONVERT.
- Reset, including mid-conversion:
  - State goes to IDLE.
  - `seg0`..`seg3` = 1111111; `busy`, `done`, `overflow` = 0.
  - The partial conversion is discarded.

## Timing
- `load` sampled at edge T → CONVERT steps at edges T+1..T+14 → UPDATE at edge T+15.
- New segments and `done`=1 are visible after edge T+15.
- `busy` is high for exactly 15 cycles (after T through after T+14) and low in the `done` cycle.
- `load` asserted during the `done` cycle is accepted (state is IDLE).
- Back-to-back conversions: one result every 16 cycles.
- `done` never lasts more than one cycle.

## Configuration
- `SEGMENT_FORMATTER_LZB_EN` defined: leading-zero blanking.
  - `seg3`, then `seg2`, then `seg1` are blanked (1111111) while they and all higher digits are zero.
  - `seg0` always shows its digit.
  - Does not apply to the overflow dash pattern.
- Undefined: all four digits always display, e.g. 7 → "0007".

## Structure
- Shared package `segment_pkg`:
  - Digit pattern constants `SEG_DIGIT[0:9]`, `SEG_BLANK`, `SEG_DASH`.
  - State enum `fmt_state_t`.
  - `BCD_DIGITS`=4 and `MAX_DISPLAY`=9999.
- Sub-module `bcd_to_seg`: combinational 4-bit BCD → 7-bit pattern decoder, instantiated four times; non-BCD codes map to `SEG_BLANK`.

## Test plan
- Assert `rst_n`=0 → all segments 1111111; `busy`/`done`/`overflow`=0; no `done` until the first `load`.
- `load` with `value`=1234 → 16 cycles later `seg3..seg0` = 1111001, 0100100, 0110000, 0011001; `done` pulses once; `busy` high for 15 cycles.
- `value`=7, built with and without the macro:
  - Without macro → 1000000 ×3 then 1111000.
  - With macro → 1111111 ×3 then 1111000.
- `value`=9999 → four ×0010000, `overflow`=0. Then `value`=10000 → four ×0111111, `overflow`=1.
- `load` pulses at cycles 3 and 8 after an accepted `load` → ignored; exactly one `done`; outputs reflect the first value.
- `rst_n` low at conversion step 6, then a fresh `load` of 42 → outputs blank during reset; afterwards "0042" (or blank-blank-4-2 with the macro).
